// File: rtl/fgyrus_pcm_fetch.sv
// fgyrus_pcm_fetch
//   Frame fetch sequencer between the Audio Cortex PCM buffer and the Fgyrus
//   FFT input. On a rising edge of the frame-ready level it reads every
//   left/right sample through the buffer's address/data port. It forms one
//   output sample per index (mono average, left only or right only) and
//   streams the samples out over valid/ready through a small FIFO. Reads are
//   issued only against FIFO credit, so returning data always has a slot.
//
//   State table
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | waiting for a frame-ready edge, no frame in progress
//   S_FETCH  | issuing buffer reads, paced by FIFO credit
//   S_DRAIN  | all reads issued, waiting for the last sample to be taken
//
// Ports
//   clk, rst     single clock, synchronous active-high reset
//   pcm_rdy      frame-ready level from the PCM buffer
//   pcm_addr     buffer read address {channel, index}, channel 1 = right
//   pcm_data     signed sample, valid RD_LATENCY cycles after pcm_addr
//   mode         0 mono average, 1 left, 2 right, 3 same as 0; latched per frame
//   smpl_valid / smpl_ready / smpl_data / smpl_idx / smpl_last
//                output stream to the FFT core
//   busy         frame in progress
//   ovr_pulse    one cycle: frame-ready edge seen while busy (edge ignored)
//   frame_cnt    completed frames, wraps
module fgyrus_pcm_fetch #(
    parameter int NUM_SAMPLES = 128,
    parameter int MEM_ADDR_W  = $clog2(NUM_SAMPLES) + 1,
    parameter int RD_LATENCY  = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pcm_rdy,
    output logic [MEM_ADDR_W-1:0]          pcm_addr,
    input  logic [31:0]                    pcm_data,
    input  logic [1:0]                     mode,
    output logic                           smpl_valid,
    input  logic                           smpl_ready,
    output logic [31:0]                    smpl_data,
    output logic [$clog2(NUM_SAMPLES)-1:0] smpl_idx,
    output logic                           smpl_last,
    output logic                           busy,
    output logic                           ovr_pulse,
    output logic [15:0]                    frame_cnt
);

    localparam int IDX_W = $clog2(NUM_SAMPLES);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] MODE_MONO  = 2'd0;
    localparam logic [1:0] MODE_RIGHT = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  rdy_q, rdy_qq;
    logic                  frame_start;
    logic [1:0]            mode_q;
    logic [IDX_W-1:0]      iss_idx_q;
    logic                  slot_q;
    logic [RD_LATENCY:0]   sr_vld_q;
    logic [RD_LATENCY:0]   sr_push_q;
    logic [31:0]           l_hold_q;
    logic [CNT_W-1:0]      inflight_q;
    logic [31:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;
    logic [IDX_W-1:0]      out_idx_q;
    logic [15:0]           frame_cnt_q;
    logic                  ovr_q;
    logic [MEM_ADDR_W-1:0] addr_q;

    logic                  issue, issue_new, issue_push;
    logic [MEM_ADDR_W-1:0] issue_addr;
    logic                  frame_done;
    logic                  ret, push, pop;
    logic signed [32:0]    mono_sum;
    logic [31:0]           push_data;
    logic [CNT_W:0]        commit;
    logic                  credit_ok;

    assign frame_start = rdy_q & ~rdy_qq;

    assign smpl_valid = (fifo_cnt_q != '0);
    assign pop        = smpl_valid & smpl_ready;
    assign smpl_data  = fifo_mem[rd_ptr_q];
    assign smpl_idx   = out_idx_q;
    assign smpl_last  = smpl_valid && (out_idx_q == IDX_LAST);
    assign busy       = (state_q != S_IDLE);
    assign ovr_pulse  = ovr_q;
    assign frame_cnt  = frame_cnt_q;
    assign pcm_addr   = addr_q;

    // Tag pipeline output: a read issued RD_LATENCY+1 edges ago has its data
    // on pcm_data now. Only the read that completes an index pushes.
    assign ret  = sr_vld_q[RD_LATENCY];
    assign push = ret & sr_push_q[RD_LATENCY];

    // 33-bit sum so L+R cannot overflow; >>> floors toward minus infinity.
    assign mono_sum  = $signed({l_hold_q[31], l_hold_q}) + $signed({pcm_data[31], pcm_data});
    assign push_data = (mode_q == MODE_MONO) ? 32'(mono_sum >>> 1) : pcm_data;

    // Every issued index will eventually occupy one FIFO slot. The entry
    // leaving this cycle is already counted as free, which keeps the
    // single-channel stream at one sample per cycle with the minimum depth.
    assign commit    = {1'b0, fifo_cnt_q} + {1'b0, inflight_q} - {{CNT_W{1'b0}}, pop};
    assign credit_ok = (commit < (CNT_W + 1)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_new  = 1'b0;
        issue_push = 1'b0;
        issue_addr = '0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mode_q == MODE_MONO) begin
                    if (!slot_q) begin
                        if (credit_ok) begin
                            issue      = 1'b1;
                            issue_new  = 1'b1;
                            issue_addr = {1'b0, iss_idx_q};
                        end
                    end else begin
                        // Right half of a pair was credited with its left half.
                        issue      = 1'b1;
                        issue_push = 1'b1;
                        issue_addr = {1'b1, iss_idx_q};
                        if (iss_idx_q == IDX_LAST) begin
                            state_d = S_DRAIN;
                        end
                    end
                end else begin
                    if (credit_ok) begin
                        issue      = 1'b1;
                        issue_new  = 1'b1;
                        issue_push = 1'b1;
                        issue_addr = {(mode_q == MODE_RIGHT), iss_idx_q};
                        if (iss_idx_q == IDX_LAST) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (pop && smpl_last) begin
                    state_d    = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q       <= 1'b0;
            rdy_qq      <= 1'b0;
            ovr_q       <= 1'b0;
            mode_q      <= MODE_MONO;
            iss_idx_q   <= '0;
            slot_q      <= 1'b0;
            sr_vld_q    <= '0;
            sr_push_q   <= '0;
            l_hold_q    <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            out_idx_q   <= '0;
            frame_cnt_q <= '0;
            addr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            rdy_q  <= pcm_rdy;
            rdy_qq <= rdy_q;
            ovr_q  <= frame_start && (state_q != S_IDLE);

            if (state_q == S_IDLE && frame_start) begin
                mode_q    <= (mode == 2'd3) ? MODE_MONO : mode;
                iss_idx_q <= '0;
                slot_q    <= 1'b0;
                out_idx_q <= '0;
            end

            if (issue) begin
                addr_q <= issue_addr;
                if (mode_q == MODE_MONO) begin
                    slot_q <= ~slot_q;
                end
                if (issue_push) begin
                    iss_idx_q <= iss_idx_q + 1'b1;
                end
            end

            sr_vld_q  <= {sr_vld_q[RD_LATENCY-1:0], issue};
            sr_push_q <= {sr_push_q[RD_LATENCY-1:0], issue_push};

            if (ret && !sr_push_q[RD_LATENCY]) begin
                l_hold_q <= pcm_data;
            end

            case ({issue_new, push})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase

            if (push) begin
                fifo_mem[wr_ptr_q] <= push_data;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                out_idx_q <= out_idx_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase

            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

endmodule
